// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: selects load data (byte/half/word/LWL/LWR/SC)
// and registers the register-file and HI/LO write ports plus the LL bit.
module mem_wb_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_mem,
  input  logic        stall_wb,
  input  logic        flush,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_ldop,
  input  logic [1:0]  mem_addr_lo,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] mem_rt,
  input  logic        mem_ll,
  input  logic        mem_sc,
  input  logic        mem_whilo,
  input  logic [31:0] mem_hi,
  input  logic [31:0] mem_lo,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        wb_whilo,
  output logic [31:0] wb_hi,
  output logic [31:0] wb_lo,
  output logic        llbit_o
);

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_LB   = 3'b001,
    LD_LBU  = 3'b010,
    LD_LH   = 3'b011,
    LD_LHU  = 3'b100,
    LD_LW   = 3'b101,
    LD_LWL  = 3'b110,
    LD_LWR  = 3'b111
  } ldop_e;

  typedef enum logic [1:0] {
    ACT_CAPTURE,
    ACT_HOLD,
    ACT_CLEAR
  } act_e;

  act_e        act;
  ldop_e       op;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        misaligned;
  logic [31:0] wdata_next;

  always_comb begin
    if (rst || flush)
      act = ACT_CLEAR;
    else if (stall_mem && !stall_wb)
      act = ACT_CLEAR;
    else if (stall_wb)
      act = ACT_HOLD;
    else
      act = ACT_CAPTURE;
  end

  // Big-endian lanes: address 0 is the most significant byte.
  always_comb begin
    byte_sel = 8'h00;
    case (mem_addr_lo)
      2'd0: byte_sel = mem_rdata[31:24];
      2'd1: byte_sel = mem_rdata[23:16];
      2'd2: byte_sel = mem_rdata[15:8];
      2'd3: byte_sel = mem_rdata[7:0];
      default: byte_sel = 8'h00;
    endcase
    half_sel = mem_addr_lo[1] ? mem_rdata[15:0] : mem_rdata[31:16];
  end

  always_comb begin
    op         = ldop_e'(mem_ldop);
    misaligned = 1'b0;
    wdata_next = mem_wdata;
    if (mem_sc) begin
      wdata_next = {31'b0, llbit_o};
    end else begin
      case (op)
        LD_NONE: wdata_next = mem_wdata;
        LD_LB:   wdata_next = {{24{byte_sel[7]}}, byte_sel};
        LD_LBU:  wdata_next = {24'b0, byte_sel};
        LD_LH: begin
          misaligned = mem_addr_lo[0];
          wdata_next = misaligned ? '0 : {{16{half_sel[15]}}, half_sel};
        end
        LD_LHU: begin
          misaligned = mem_addr_lo[0];
          wdata_next = misaligned ? '0 : {16'b0, half_sel};
        end
        LD_LW: begin
          misaligned = (mem_addr_lo != 2'd0);
          wdata_next = misaligned ? '0 : mem_rdata;
        end
        LD_LWL: begin
          case (mem_addr_lo)
            2'd0: wdata_next = mem_rdata;
            2'd1: wdata_next = {mem_rdata[23:0], mem_rt[7:0]};
            2'd2: wdata_next = {mem_rdata[15:0], mem_rt[15:0]};
            2'd3: wdata_next = {mem_rdata[7:0], mem_rt[23:0]};
            default: wdata_next = mem_rdata;
          endcase
        end
        LD_LWR: begin
          case (mem_addr_lo)
            2'd0: wdata_next = {mem_rt[31:8], mem_rdata[31:24]};
            2'd1: wdata_next = {mem_rt[31:16], mem_rdata[31:16]};
            2'd2: wdata_next = {mem_rt[31:24], mem_rdata[31:8]};
            2'd3: wdata_next = mem_rdata;
            default: wdata_next = mem_rdata;
          endcase
        end
        default: wdata_next = mem_wdata;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (act == ACT_CLEAR) begin
      wb_wd    <= '0;
      wb_wreg  <= 1'b0;
      wb_wdata <= '0;
      wb_whilo <= 1'b0;
      wb_hi    <= '0;
      wb_lo    <= '0;
    end else if (act == ACT_CAPTURE) begin
      wb_wd    <= mem_wd;
      wb_wreg  <= mem_wreg & ~misaligned;
      wb_wdata <= wdata_next;
      wb_whilo <= mem_whilo;
      wb_hi    <= mem_hi;
      wb_lo    <= mem_lo;
    end
  end

  // LL bit survives bubbles; only reset/flush or a captured LL/SC changes it.
  always_ff @(posedge clk) begin
    if (rst || flush)
      llbit_o <= 1'b0;
    else if (act == ACT_CAPTURE) begin
      if (mem_sc)
        llbit_o <= 1'b0;
      else if (mem_ll)
        llbit_o <= 1'b1;
    end
  end

endmodule
